regbank_wb_arbiter: RTL and testbench
=====================================

Name: regbank_wb_arbiter

Overview:
Write-back controller for the 8 x 16-bit register bank. It arbitrates the bank's single write port between the ALU and the load unit using round-robin valid/ready handshakes, and drives the bank's one-hot write enable and write data. A busy scoreboard, reserved at issue and cleared at write-back, flags read-after-write hazards on the two bank read selects.

Parameters:
DATA_W, 16, write-back data width; must match the bank word width.
NREGS, 8, register count; the select width is log2(NREGS) = 3.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU write-back request
alu_ready  out  1  ALU request granted this cycle
alu_dest  in  3  ALU destination register
alu_data  in  16  ALU result
mem_valid  in  1  load-unit write-back request
mem_ready  out  1  load-unit request granted this cycle
mem_dest  in  3  load destination register
mem_data  in  16  load data
rsv_valid  in  1  issue stage reserves a destination
rsv_dest  in  3  register being reserved
sel0  in  3  bank read select 0 (from decode)
sel1  in  3  bank read select 1 (from decode)
hazard  out  1  a read select or the reservation targets a busy register
wb_en  out  8  one-hot write enable to the bank
wb_data  out  16  write data to the bank
busy  out  8  scoreboard; bit i set means Ri has a write pending

Behaviour:
- Reset (synchronous) forces wb_en=0, wb_data=0, busy=0 and rr_last=MEM, so the ALU wins the first tie. Reset overrides every other event in the same cycle; an in-flight grant is discarded.
- Arbitration is combinational from the valid inputs and rr_last:
  - Only one requester valid: it is granted.
  - Both valid: grant the one that is not rr_last.
  - Neither valid: no grant.
  - Exactly one of alu_ready / mem_ready is high when a grant occurs; ready is never high without the matching valid.
- A handshake is valid & ready at a rising edge. On a handshake at edge N:
  - wb_en <= one-hot(dest); wb_data <= data; rr_last <= the granted source.
  - The bank captures the value at edge N+1.
- With no handshake, wb_en <= 0 and wb_data holds its value.
- The losing requester holds valid, dest and data stable until it is granted.
- Scoreboard update at every edge, in this order:
  1. Clear busy bits where wb_en is high (the write completing at this edge).
  2. Set busy[rsv_dest] if rsv_valid.
  - Set wins over clear on the same bit, so back-to-back reuse of a register stays busy.
- Reserving a register that is already busy leaves it set. Issue must stall on hazard, so this case is not expected.
- hazard = busy[sel0] | busy[sel1] | (rsv_valid & busy[rsv_dest]).
  - Purely combinational from registered busy.
  - It deasserts in the cycle after the bank write edge, so the reads see the new value.
- A write-back to a register that is not busy is legal: it is written and the scoreboard does not change.
- Both requesters targeting the same register in the same cycle: the winner writes first and the loser writes one or more cycles later, so the last writer wins. Ordering is the issue stage's responsibility.
- Write-back throughput is one write per cycle, with no bubble between consecutive grants.

Optional Feature:
Macro REG0_ZERO_EN.
- Defined: R0 is hardwired to zero.
  - wb_en[0] is never asserted.
  - busy[0] is never set.
  - A handshake targeting R0 still completes (ready is asserted), but the write is dropped.
  - rsv_dest=0 and sel=0 never raise hazard.
- Undefined: R0 behaves like every other register.

Decomposition:
- Shared package regbank_pkg holds DATA_W, NREGS and SEL_W=3, plus the source enum {SRC_ALU=0, SRC_MEM=1} used for rr_last.
- One sub-module, rr_arbiter2: a 2-input round-robin grant with a last-grant register and an update-on-handshake input. It is reusable by other shared resources.
- Scoreboard, one-hot decode and output registers stay in the top module.

Test Plan:
- Reset, then alu_valid with alu_dest=3, alu_data=16'h00F0 -> alu_ready=1 the same cycle; the next cycle wb_en=8'b0000_1000 and wb_data=16'h00F0; the cycle after, wb_en=0.
- Both valid for 4 cycles (ALU dest=1, data=16'h0001, held until granted; MEM dest=2, data=16'h0002, held until granted; each re-asserted with a new dest/data after its grant) -> grants alternate ALU, MEM, ALU, MEM; wb_en sequence is 02, 04, 02, 04 (hex).
- rsv_valid with rsv_dest=5 -> busy=8'h20; sel0=5 gives hazard=1; MEM write-back to R5 with mem_data=16'hBEEF -> busy clears at the edge where wb_en=8'h20; hazard=0 in the following cycle.
- rsv_dest=4 reserved in the same cycle that wb_en=8'h10 completes an older R4 write -> busy[4] remains 1.
- Reset asserted while alu_valid=1 and wb_en=8'h08 -> next cycle wb_en=0, busy=0, ready not asserted during reset; after release, the ALU wins the first tie.
- With REG0_ZERO_EN, alu_dest=0 and alu_data=16'hFFFF -> alu_ready=1, wb_en stays 0, busy[0]=0; without the macro, wb_en=8'h01.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and sizes for the register bank write-back path.
package regbank_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   function automatic logic [NREGS-1:0] dec_onehot(input logic [SEL_W-1:0] sel);
      dec_onehot      = '0;
      dec_onehot[sel] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the last-grant register advances only on a
// completed handshake so a held request keeps its turn.
module rr_arbiter2
   import regbank_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt,
   output src_e       last
);

   // Grants are suppressed during reset so nothing handshakes into a discarded cycle.
   always_comb begin
      gnt    = '0;
      gnt[0] = !reset && req[0] && (!req[1] || last == SRC_MEM);
      gnt[1] = !reset && req[1] && (!req[0] || last == SRC_ALU);
   end

   always_ff @(posedge clk) begin
      if (reset)
         last <= SRC_MEM;
      else if (upd)
         last <= gnt[1] ? SRC_MEM : SRC_ALU;
   end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Write-back controller for the 8x16 register bank: ALU/load arbitration,
// one-hot write port drive and busy scoreboard. Option: REG0_ZERO_EN (R0 reads as zero).
module regbank_wb_arbiter
   import regbank_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [SEL_W-1:0]  alu_dest,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [SEL_W-1:0]  mem_dest,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              rsv_valid,
   input  logic [SEL_W-1:0]  rsv_dest,
   input  logic [SEL_W-1:0]  sel0,
   input  logic [SEL_W-1:0]  sel1,
   output logic              hazard,
   output logic [NREGS-1:0]  wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic [NREGS-1:0]  busy
);

`ifdef REG0_ZERO_EN
   localparam logic [NREGS-1:0] R0_MASK = {{(NREGS-1){1'b1}}, 1'b0};
`else
   localparam logic [NREGS-1:0] R0_MASK = '1;
`endif

   logic [1:0]       gnt;
   src_e             last;
   logic             hs_alu, hs_mem;
   logic [NREGS-1:0] set_mask;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({mem_valid, alu_valid}),
      .upd   (hs_alu || hs_mem),
      .gnt   (gnt),
      .last  (last)
   );

   assign alu_ready = gnt[0];
   assign mem_ready = gnt[1];
   assign hs_alu    = alu_valid && alu_ready;
   assign hs_mem    = mem_valid && mem_ready;

   assign set_mask = rsv_valid ? (dec_onehot(rsv_dest) & R0_MASK) : '0;

   // busy[0] can never be set under REG0_ZERO_EN, so R0 never raises a hazard.
   assign hazard = busy[sel0] || busy[sel1] || (rsv_valid && busy[rsv_dest]);

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_en   <= '0;
         wb_data <= '0;
         busy    <= '0;
      end else begin
         if (hs_alu) begin
            wb_en   <= dec_onehot(alu_dest) & R0_MASK;
            wb_data <= alu_data;
         end else if (hs_mem) begin
            wb_en   <= dec_onehot(mem_dest) & R0_MASK;
            wb_data <= mem_data;
         end else begin
            wb_en   <= '0;
         end
         // Set after clear: a register re-reserved as its old write lands stays busy.
         busy <= (busy & ~wb_en) | set_mask;
      end
   end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench: stimulus pushes expected bank writes into a queue, a monitor
// pops and compares each nonzero wb_en; control outputs are checked inline.
module tb_regbank_wb_arbiter;
   import regbank_pkg::*;

   typedef struct packed {
      logic [NREGS-1:0]  en;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              alu_valid, mem_valid, rsv_valid;
   logic              alu_ready, mem_ready, hazard;
   logic [SEL_W-1:0]  alu_dest, mem_dest, rsv_dest, sel0, sel1;
   logic [DATA_W-1:0] alu_data, mem_data, wb_data;
   logic [NREGS-1:0]  wb_en, busy;

   int  checks = 0;
   int  errors = 0;
   wr_t expq[$];

   regbank_wb_arbiter dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
      .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .sel0(sel0), .sel1(sel1),
      .hazard(hazard), .wb_en(wb_en), .wb_data(wb_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [NREGS-1:0] en, input logic [DATA_W-1:0] d);
      wr_t w;
      w.en   = en;
      w.data = d;
      expq.push_back(w);
   endtask

   // Monitor: every presented bank write must match the oldest expected one.
   always @(negedge clk) begin
      if (wb_en !== '0) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got en=%0h data=%0h expected none", wb_en, wb_data);
         end else begin
            wr_t w;
            w = expq.pop_front();
            if (wb_en !== w.en || wb_data !== w.data) begin
               errors++;
               $display("FAIL write: got en=%0h data=%0h expected en=%0h data=%0h",
                        wb_en, wb_data, w.en, w.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Tie-break table: ALU data/dest, MEM data/dest per cycle and expected grant.
   logic [DATA_W-1:0] t_alu_d [4] = '{16'h0001, 16'h0011, 16'h0011, 16'h0111};
   logic [DATA_W-1:0] t_mem_d [4] = '{16'h0002, 16'h0002, 16'h0022, 16'h0022};
   logic              t_galu  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [NREGS-1:0]  t_en    [4] = '{8'h02, 8'h04, 8'h02, 8'h04};

   initial begin
      reset = 1'b1;
      alu_valid = 0; mem_valid = 0; rsv_valid = 0;
      alu_dest = 0; mem_dest = 0; rsv_dest = 0; sel0 = 0; sel1 = 0;
      alu_data = 0; mem_data = 0;
      step(); step();
      chk("reset_wb_en", 32'(wb_en), 0);
      chk("reset_wb_data", 32'(wb_data), 0);
      chk("reset_busy", 32'(busy), 0);
      reset = 1'b0;

      // Single ALU write to R3
      alu_valid = 1; alu_dest = 3; alu_data = 16'h00F0;
      #1;
      chk("t1_alu_ready", 32'(alu_ready), 1);
      chk("t1_mem_ready", 32'(mem_ready), 0);
      push(8'h08, 16'h00F0);
      step();
      alu_valid = 0;
      step();
      chk("t1_wb_en_idle", 32'(wb_en), 0);
      chk("t1_wb_data_hold", 32'(wb_data), 32'h00F0);

      // Fresh arbiter state, then four cycles with both requesting
      reset = 1; step(); reset = 0;
      alu_dest = 1; mem_dest = 2;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1; mem_valid = 1;
         alu_data = t_alu_d[i]; mem_data = t_mem_d[i];
         #1;
         chk($sformatf("t2_alu_ready%0d", i), 32'(alu_ready), 32'(t_galu[i]));
         chk($sformatf("t2_mem_ready%0d", i), 32'(mem_ready), 32'(!t_galu[i]));
         push(t_en[i], t_galu[i] ? t_alu_d[i] : t_mem_d[i]);
         step();
      end
      alu_valid = 0; mem_valid = 0;
      step();

      // Reserve R5, hazard, MEM write-back clears it
      rsv_valid = 1; rsv_dest = 5;
      step();
      rsv_valid = 0;
      chk("t3_busy_set", 32'(busy), 32'h20);
      sel0 = 5;
      #1;
      chk("t3_hazard_on", 32'(hazard), 1);
      mem_valid = 1; mem_dest = 5; mem_data = 16'hBEEF;
      #1;
      chk("t3_mem_ready", 32'(mem_ready), 1);
      push(8'h20, 16'hBEEF);
      step();
      mem_valid = 0;
      chk("t3_busy_while_write", 32'(busy), 32'h20);
      chk("t3_hazard_while_write", 32'(hazard), 1);
      step();
      chk("t3_busy_cleared", 32'(busy), 0);
      chk("t3_hazard_off", 32'(hazard), 0);
      sel0 = 0;

      // Re-reserve R4 on the edge its older write completes
      rsv_valid = 1; rsv_dest = 4;
      step();
      rsv_valid = 0;
      alu_valid = 1; alu_dest = 4; alu_data = 16'h1234;
      push(8'h10, 16'h1234);
      step();
      alu_valid = 0;
      chk("t4_wb_en", 32'(wb_en), 32'h10);
      rsv_valid = 1; rsv_dest = 4;
      step();
      rsv_valid = 0;
      chk("t4_busy_kept", 32'(busy), 32'h10);

      // Reset while a grant is in flight
      alu_valid = 1; alu_dest = 3; alu_data = 16'h0AAA;
      push(8'h08, 16'h0AAA);
      step();
      chk("t5_wb_en_inflight", 32'(wb_en), 32'h08);
      reset = 1;
      #1;
      chk("t5_ready_in_reset", 32'({alu_ready, mem_ready}), 0);
      step();
      chk("t5_wb_en_reset", 32'(wb_en), 0);
      chk("t5_busy_reset", 32'(busy), 0);
      chk("t5_ready_in_reset2", 32'({alu_ready, mem_ready}), 0);
      reset = 0;
      alu_dest = 6; alu_data = 16'h6666;
      mem_valid = 1; mem_dest = 7; mem_data = 16'h7777;
      #1;
      chk("t5_tie_alu_first", 32'({alu_ready, mem_ready}), 32'b10);
      push(8'h40, 16'h6666);
      step();
      alu_valid = 0;
      #1;
      chk("t5_mem_second", 32'(mem_ready), 1);
      push(8'h80, 16'h7777);
      step();
      mem_valid = 0;

      // Write to R0
      alu_valid = 1; alu_dest = 0; alu_data = 16'hFFFF;
      #1;
      chk("t6_alu_ready", 32'(alu_ready), 1);
`ifndef REG0_ZERO_EN
      push(8'h01, 16'hFFFF);
`endif
      step();
      alu_valid = 0;
`ifdef REG0_ZERO_EN
      chk("t6_wb_en_dropped", 32'(wb_en), 0);
`else
      chk("t6_wb_en_r0", 32'(wb_en), 32'h01);
`endif
      rsv_valid = 1; rsv_dest = 0;
      #1;
      chk("t6_hazard_r0", 32'(hazard), 0);
      step();
      rsv_valid = 0;
`ifdef REG0_ZERO_EN
      chk("t6_busy_r0", 32'(busy), 0);
`else
      chk("t6_busy_r0", 32'(busy), 32'h01);
`endif
      step(); step();
      chk("drain_queue_empty", 32'(expq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
